// File: rtl/intr_sched_pkg.sv
// Shared types and constants for the interrupt stimulus scheduler.
// Command fields are carried at fixed 32-bit width; instances zero-extend their narrower ports.
package intr_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int CMD_LINE_W  = 32;
   localparam int CMD_DELAY_W = 32;
   localparam int CMD_HOLD_W  = 32;

   // A hold of zero means "raise and leave asserted until the mailbox clears it".
   localparam logic [CMD_HOLD_W-1:0] HOLD_LEVEL = '0;

   typedef struct packed {
      logic [CMD_LINE_W-1:0]  line;
      logic [CMD_DELAY_W-1:0] delay;
      logic [CMD_HOLD_W-1:0]  hold;
   } cmd_t;

endpackage

// File: rtl/intr_delay_counter.sv
// Loadable down-counter that stops at zero; reused for both the delay and the hold phase.
module intr_delay_counter #(
   parameter int W = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/intr_stim_scheduler.sv
// Drives interrupt lines on a programmed schedule: one command at a time, pulse or level mode.
// Handshake: a command is taken on any edge where cmd_valid and cmd_ready are both high.
module intr_stim_scheduler
   import intr_sched_pkg::*;
#(
   parameter  int ID      = 0,
   parameter  int WIDTH   = 1,
   parameter  int DELAY_W = 16,
   parameter  int HOLD_W  = 16,
   localparam int LINE_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [LINE_W-1:0]  cmd_line,
   input  logic [DELAY_W-1:0] cmd_delay,
   input  logic [HOLD_W-1:0]  cmd_hold,
   input  logic               clear_valid,
   input  logic [LINE_W-1:0]  clear_line,
   output logic [WIDTH-1:0]   interrupts,
   output logic               busy,
   output logic               cmd_done,
   output logic               cmd_err
);

   state_t                 state;
   state_t                 state_nxt;
   cmd_t                   cmd_in;
   logic                   accept;
   logic                   cnt_load;
   logic [CMD_DELAY_W-1:0] cnt_value;
   logic                   cnt_zero;
   logic                   set_line;
   logic                   end_pulse;
   logic                   finish;
   logic [CMD_LINE_W-1:0]  line_q;
   logic [CMD_HOLD_W-1:0]  hold_q;
   logic                   preowned_q;
   logic                   preowned_d;
   logic                   done_q;
   logic                   err_q;
   logic [WIDTH-1:0]       irq_q;
   logic [WIDTH-1:0]       irq_nxt;
   logic                   unused_id;

   assign unused_id = (ID == 0);

   assign cmd_in = '{line:  CMD_LINE_W'(cmd_line),
                     delay: CMD_DELAY_W'(cmd_delay),
                     hold:  CMD_HOLD_W'(cmd_hold)};

   assign cmd_ready = (state == IDLE) && !reset;
   assign accept    = cmd_valid && cmd_ready;

   intr_delay_counter #(.W(CMD_DELAY_W)) u_counter (
      .clock (clock),
      .reset (reset),
      .load  (cnt_load),
      .value (cnt_value),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Hold is reloaded as hold-1 so the pulse ends on the edge the counter reads zero.
   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_value = '0;
      set_line  = 1'b0;
      end_pulse = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = WAIT;
               cnt_load  = 1'b1;
               cnt_value = cmd_in.delay;
            end
         end
         WAIT: begin
            if (cnt_zero) begin
               set_line = 1'b1;
               if (hold_q == HOLD_LEVEL) begin
                  state_nxt = IDLE;
                  finish    = 1'b1;
               end else begin
                  state_nxt = HOLD;
                  cnt_load  = 1'b1;
                  cnt_value = hold_q - CMD_HOLD_W'(1);
               end
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               end_pulse = 1'b1;
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Clear is applied first so a same-edge set overrides it; out-of-range lines match nothing.
   always_comb begin
      irq_nxt    = irq_q;
      preowned_d = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (clear_valid && (CMD_LINE_W'(clear_line) == CMD_LINE_W'(i))) begin
            irq_nxt[i] = 1'b0;
         end
         if (line_q == CMD_LINE_W'(i)) begin
            if (set_line) begin
               preowned_d = irq_q[i] &&
                            !(clear_valid && (CMD_LINE_W'(clear_line) == CMD_LINE_W'(i)));
               irq_nxt[i] = 1'b1;
            end
            if (end_pulse && !preowned_q) begin
               irq_nxt[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         line_q     <= '0;
         hold_q     <= '0;
         preowned_q <= 1'b0;
         irq_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (accept) begin
            line_q <= cmd_in.line;
            hold_q <= cmd_in.hold;
         end
         if (set_line) begin
            preowned_q <= preowned_d;
         end
         irq_q  <= irq_nxt;
         done_q <= finish;
         err_q  <= finish && (line_q >= CMD_LINE_W'(WIDTH));
      end
   end

   assign interrupts = irq_q;
   assign busy       = (state != IDLE);
   assign cmd_done   = done_q;
   assign cmd_err    = err_q;

endmodule

// File: tb/tb_intr_stim_scheduler.sv
// Randomised bench for intr_stim_scheduler against an edge-indexed schedule model.
module tb_intr_stim_scheduler;

   localparam int WIDTH   = 5;
   localparam int DELAY_W = 16;
   localparam int HOLD_W  = 16;
   localparam int LINE_W  = 3;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic [LINE_W-1:0]  cmd_line = '0;
   logic [DELAY_W-1:0] cmd_delay = '0;
   logic [HOLD_W-1:0]  cmd_hold = '0;
   logic               clear_valid = 1'b0;
   logic [LINE_W-1:0]  clear_line = '0;
   logic [WIDTH-1:0]   interrupts;
   logic               busy;
   logic               cmd_done;
   logic               cmd_err;

   int checks = 0;
   int errors = 0;

   // Each entry: {expected cmd_err, edge index after which cmd_done is high}.
   logic [31:0] exp_q[$];
   logic [31:0] mon_e;

   int               edge_n = 0;
   bit               act = 1'b0;
   bit               was_act;
   logic [LINE_W-1:0] m_line;
   int               m_rise;
   int               m_end;
   int               m_hold;
   bit               m_preown = 1'b0;
   logic [WIDTH-1:0] exp_irq = '0;
   logic [WIDTH-1:0] nxt;
   bit               exp_busy = 1'b0;
   bit               rand_done = 1'b0;

   intr_stim_scheduler #(
      .ID      (0),
      .WIDTH   (WIDTH),
      .DELAY_W (DELAY_W),
      .HOLD_W  (HOLD_W)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_line    (cmd_line),
      .cmd_delay   (cmd_delay),
      .cmd_hold    (cmd_hold),
      .clear_valid (clear_valid),
      .clear_line  (clear_line),
      .interrupts  (interrupts),
      .busy        (busy),
      .cmd_done    (cmd_done),
      .cmd_err     (cmd_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h edge=%0d", name, actual, expected, edge_n);
      end
   endtask

   // Reference: every command is a set of absolute edge numbers (rise, fall, completion).
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         exp_irq  = '0;
         act      = 1'b0;
         exp_busy = 1'b0;
         m_preown = 1'b0;
         exp_q.delete();
      end else begin
         edge_n++;
         was_act = act;
         nxt     = exp_irq;
         if (clear_valid && int'(clear_line) < WIDTH) nxt[clear_line] = 1'b0;
         if (act && edge_n == m_rise && int'(m_line) < WIDTH) begin
            m_preown     = exp_irq[m_line] && !(clear_valid && clear_line == m_line);
            nxt[m_line]  = 1'b1;
         end
         if (act && m_hold != 0 && edge_n == m_rise + m_hold && int'(m_line) < WIDTH && !m_preown)
            nxt[m_line] = 1'b0;
         if (act && edge_n == m_end) act = 1'b0;
         if (cmd_valid && !was_act) begin
            act    = 1'b1;
            m_line = cmd_line;
            m_hold = int'(cmd_hold);
            m_rise = edge_n + 1 + int'(cmd_delay);
            m_end  = (m_hold == 0) ? m_rise : m_rise + m_hold;
            exp_q.push_back({(int'(m_line) >= WIDTH), 31'(m_end)});
         end
         exp_irq  = nxt;
         exp_busy = act;
      end
   end

   // Monitor: compare lines every cycle, pop the scoreboard on each completion.
   always @(negedge clock) begin
      check("interrupts", 32'(interrupts), 32'(exp_irq));
      check("busy", 32'(busy), 32'(exp_busy));
      check("cmd_ready", 32'(cmd_ready), 32'(!exp_busy && !reset));
      if (cmd_done) begin
         if (exp_q.size() == 0) begin
            check("cmd_done_unexpected", 32'(cmd_done), 32'(0));
         end else begin
            mon_e = exp_q.pop_front();
            check("done_edge", 32'(edge_n), {1'b0, mon_e[30:0]});
            check("cmd_err", 32'(cmd_err), 32'(mon_e[31]));
         end
      end else begin
         check("cmd_err_alone", 32'(cmd_err), 32'(0));
         if (exp_q.size() != 0 && int'(exp_q[0][30:0]) <= edge_n) begin
            check("cmd_done_missing", 32'(cmd_done), 32'(1));
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!cmd_ready && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'(1));
   endtask

   task automatic send_cmd(input logic [LINE_W-1:0] line, input int delay, input int hold);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_line  = line;
      cmd_delay = DELAY_W'(delay);
      cmd_hold  = HOLD_W'(hold);
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic do_clear(input logic [LINE_W-1:0] line);
      clear_valid = 1'b1;
      clear_line  = line;
      @(negedge clock);
      clear_valid = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish edge=%0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);

      // Pulse with zero delay.
      send_cmd(3'd2, 0, 3);
      wait_ready();

      // Level, then mailbox clear.
      send_cmd(3'd1, 5, 0);
      wait_ready();
      repeat (8) @(negedge clock);
      do_clear(3'd1);
      check("t2_bit1_cleared", 32'(interrupts[1]), 32'(0));

      // Two back-to-back level commands, then clear one.
      send_cmd(3'd0, 0, 0);
      send_cmd(3'd3, 1, 0);
      wait_ready();
      @(negedge clock);
      check("t3_two_levels", 32'(interrupts), 32'(5'b01001));
      do_clear(3'd0);
      check("t3_after_clear", 32'(interrupts), 32'(5'b01000));
      do_clear(3'd3);

      // Clear lands on the same edge as the delayed set: set wins.
      send_cmd(3'd2, 2, 0);
      repeat (2) @(negedge clock);
      do_clear(3'd2);
      check("t4_set_wins", 32'(interrupts[2]), 32'(1));
      wait_ready();
      do_clear(3'd2);

      // Out-of-range line: normal timing, error flagged, no line moves.
      send_cmd(3'd5, 2, 2);
      wait_ready();
      @(negedge clock);
      check("t5_no_change", 32'(interrupts), 32'(0));

      // Pulse over a level-held line leaves it high.
      send_cmd(3'd4, 0, 0);
      send_cmd(3'd4, 1, 2);
      wait_ready();
      @(negedge clock);
      check("pulse_over_level", 32'(interrupts[4]), 32'(1));

      // Clear during own hold; completion timing unchanged.
      send_cmd(3'd0, 0, 4);
      repeat (2) @(negedge clock);
      do_clear(3'd0);
      wait_ready();

      // Asynchronous reset in the middle of a hold.
      send_cmd(3'd1, 1, 10);
      repeat (4) @(negedge clock);
      @(posedge clock);
      #3 reset = 1'b1;
      #1;
      check("rst_irq", 32'(interrupts), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(cmd_done), 32'(0));
      repeat (2) @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      #1 check("rst_ready_after", 32'(cmd_ready), 32'(1));

      fork
         begin
            for (int n = 0; n < 40; n++) begin
               send_cmd(3'($urandom_range(0, 7)), $urandom_range(0, 6),
                        ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 5));
               repeat ($urandom_range(0, 2)) @(negedge clock);
            end
            wait_ready();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(negedge clock);
               clear_valid = ($urandom_range(0, 4) == 0);
               clear_line  = 3'($urandom_range(0, 7));
            end
            clear_valid = 1'b0;
         end
      join

      repeat (3) @(negedge clock);
      check("pending_done", 32'(exp_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
